// File: rtl/adder_4bit_if.sv
// Operand/result bundle for adder_4bit: the master drives operands and
// in_valid, the slave (the adder) returns the registered result and flags.
interface adder_4bit_if;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       cin;
  logic [3:0] S;
  logic       cout;
  logic       out_valid;
  logic       ovf;
  logic       zero;

  modport master (
    output in_valid, A, B, cin,
    input  S, cout, out_valid, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, cin,
    output S, cout, out_valid, ovf, zero
  );
endinterface

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder (four full-adder stages) with a registered result,
// carry-out, signed-overflow and zero flags, and a one-cycle valid strobe.
module adder_4bit (
  input  logic         clk,
  input  logic         rst,
  adder_4bit_if.slave  bus
);

  logic [4:0] carry;
  logic [3:0] sum_d;
  logic       ovf_d;
  logic       zero_d;

  logic [3:0] s_q;
  logic       cout_q;
  logic       ovf_q;
  logic       zero_q;
  logic       valid_q;

  assign carry[0] = bus.cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      logic prop;
      assign prop          = bus.A[gi] ^ bus.B[gi];
      assign sum_d[gi]     = prop ^ carry[gi];
      assign carry[gi + 1] = (bus.A[gi] & bus.B[gi]) | (carry[gi] & prop);
    end
  endgenerate

  // Overflow: same-sign operands whose sum changed sign.
  assign ovf_d  = (bus.A[3] == bus.B[3]) && (sum_d[3] != bus.A[3]);
  assign zero_d = (sum_d == 4'b0000);

  // Result registers load only on in_valid, so unknown operands on idle
  // cycles never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= 4'b0000;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q    <= sum_d;
        cout_q <= carry[4];
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed, hold, streaming, exhaustive and
// random-idle stimulus against a plain-arithmetic reference model.
module tb_adder_4bit;

  logic clk = 1'b0;
  logic rst = 1'b0;

  adder_4bit_if bus ();

  adder_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference state: what the outputs should show right now.
  int m_s     = 0;
  int m_cout  = 0;
  int m_ovf   = 0;
  int m_zero  = 0;
  int m_valid = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".S"},         int'(bus.S),         m_s);
    check_val({tag, ".cout"},      int'(bus.cout),      m_cout);
    check_val({tag, ".ovf"},       int'(bus.ovf),       m_ovf);
    check_val({tag, ".zero"},      int'(bus.zero),      m_zero);
    check_val({tag, ".out_valid"}, int'(bus.out_valid), m_valid);
  endtask

  // Model a capture: unsigned total for sum/carry, signed total for overflow.
  task automatic model_capture(input int a, input int b, input int c);
    int total, sa, sb, stotal;
    total  = a + b + c;
    sa     = (a >= 8) ? a - 16 : a;
    sb     = (b >= 8) ? b - 16 : b;
    stotal = sa + sb + c;
    m_s    = total % 16;
    m_cout = total / 16;
    m_ovf  = (stotal > 7 || stotal < -8) ? 1 : 0;
    m_zero = (m_s == 0) ? 1 : 0;
  endtask

  // Drive at the falling edge, let the rising edge capture, check 1 time unit later.
  task automatic apply(input string tag, input int a, input int b, input int c, input int v);
    @(negedge clk);
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.cin      = 1'(c);
    bus.in_valid = 1'(v);
    @(posedge clk);
    m_valid = v;
    if (v != 0) model_capture(a, b, c);
    #1;
    n_txn++;
    $display("txn %0d %s A=%h B=%h cin=%0d v=%0d -> S=%h cout=%b ovf=%b zero=%b ov=%b",
             n_txn, tag, a, b, c, v, bus.S, bus.cout, bus.ovf, bus.zero, bus.out_valid);
    check_all(tag);
  endtask

  int dir_a[5] = '{4'b0000, 4'b0011, 4'b1110, 4'b1010, 4'b1111};
  int dir_b[5] = '{4'b0000, 4'b0101, 4'b0001, 4'b1010, 4'b1111};
  int dir_c[5] = '{0, 0, 1, 0, 1};
  // Hand-derived results for the directed vectors: S, cout, ovf, zero.
  int dir_s[5] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b1111};
  int dir_co[5] = '{0, 0, 1, 1, 1};
  int dir_ov[5] = '{0, 1, 0, 1, 0};
  int dir_z[5]  = '{1, 0, 1, 0, 0};

  initial begin
    bus.in_valid = 1'b0;
    bus.A        = 4'd0;
    bus.B        = 4'd0;
    bus.cin      = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_all("reset_init");

    @(negedge clk);
    rst = 1'b0;

    // Directed vectors against hand-computed constants.
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_c[i], 1);
      check_val($sformatf("dir%0d.S_const", i),    int'(bus.S),    dir_s[i]);
      check_val($sformatf("dir%0d.cout_const", i), int'(bus.cout), dir_co[i]);
      check_val($sformatf("dir%0d.ovf_const", i),  int'(bus.ovf),  dir_ov[i]);
      check_val($sformatf("dir%0d.zero_const", i), int'(bus.zero), dir_z[i]);
    end

    // 8+8: carry and overflow together, zero result.
    apply("both_flags", 8, 8, 0, 1);
    check_val("both_flags.const", int'({bus.cout, bus.ovf, bus.zero}), 3'b111);

    // Hold: result stays while idle operands change.
    apply("hold_load", 4'b0011, 4'b0101, 0, 1);
    apply("hold_idle", 4'b1111, 4'b1111, 1, 0);
    check_val("hold.S_const", int'(bus.S), 4'b1000);
    check_val("hold.ov_const", int'(bus.out_valid), 0);

    // Streaming: five back-to-back vectors.
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("stream%0d", i), (i * 3 + 1) % 16, (i * 7 + 5) % 16, i % 2, 1);
      check_val($sformatf("stream%0d.ov_const", i), int'(bus.out_valid), 1);
    end

    // Exhaustive sweep of all {A,B,cin}.
    for (int k = 0; k < 512; k++) begin
      apply("exh", (k >> 5) & 15, (k >> 1) & 15, k & 1, 1);
    end

    // Random operands with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      apply("rnd", int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(1)), ($urandom_range(3) != 0) ? 1 : 0);
    end

    // Asynchronous reset mid-cycle after a nonzero result.
    apply("pre_rst", 4'b0110, 4'b0011, 1, 1);
    check_val("pre_rst.nonzero", (bus.S != 4'd0) ? 1 : 0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    m_s = 0; m_cout = 0; m_ovf = 0; m_zero = 0; m_valid = 0;
    #1;
    check_all("rst_async");

    // Operands presented during reset are discarded.
    bus.A = 4'd5; bus.B = 4'd6; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_discard");
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    apply("post_rst_idle", 4'd9, 4'd9, 0, 0);
    apply("post_rst_first", 4'd9, 4'd9, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
